// File: rtl/fsm_bit_serializer.sv
// rtl/fsm_bit_serializer.sv - parallel-to-serial MSB-first feeder with valid/ready intake
// Optional even-parity frame bit enabled by defining SERIALIZER_PARITY_EN (set CNT_W accordingly).
module fsm_bit_serializer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    input  logic             shift_en,
    output logic             w,
    output logic             w_valid,
    output logic             busy
);

`ifdef SERIALIZER_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t             state, state_nxt;
    logic [FRAME-1:0]   shift_reg, shift_nxt;
    logic [CNT_W-1:0]   bit_cnt, cnt_nxt;
    logic [FRAME-1:0]   load_word;
    logic               w_valid_q;

`ifdef SERIALIZER_PARITY_EN
    assign load_word = {data_in, ^data_in};
`else
    assign load_word = data_in;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            w_valid_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            shift_reg <= shift_nxt;
            bit_cnt   <= cnt_nxt;
            w_valid_q <= (state_nxt == SHIFT);
        end
    end

    always_comb begin
        state_nxt  = state;
        shift_nxt  = shift_reg;
        cnt_nxt    = bit_cnt;
        data_ready = 1'b0;
        case (state)
            IDLE: begin
                data_ready = 1'b1;
                if (data_valid) begin
                    shift_nxt = load_word;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (shift_en) begin
                    if (bit_cnt == LAST) begin
                        data_ready = 1'b1;
                        if (data_valid) begin
                            shift_nxt = load_word;
                            cnt_nxt   = '0;
                        end else begin
                            // clearing the register keeps w low while idle
                            shift_nxt = '0;
                            cnt_nxt   = '0;
                            state_nxt = IDLE;
                        end
                    end else begin
                        shift_nxt = {shift_reg[FRAME-2:0], 1'b0};
                        cnt_nxt   = bit_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                shift_nxt = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign w       = shift_reg[FRAME-1];
    assign w_valid = w_valid_q;
    assign busy    = (state == SHIFT);

endmodule

// File: tb/tb_fsm_bit_serializer.sv
// tb/tb_fsm_bit_serializer.sv - randomized and directed bench against a bit-queue model
module tb_fsm_bit_serializer;
    localparam int WIDTH = 4;
`ifdef SERIALIZER_PARITY_EN
    localparam int CW = 3;
    localparam int FR = WIDTH + 1;
`else
    localparam int CW = 2;
    localparam int FR = WIDTH;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] data_in = '0;
    logic             data_valid = 1'b0;
    logic             data_ready, shift_en = 1'b1, w, w_valid, busy;

    int checks = 0;
    int errors = 0;

    bit         q[$];
    bit         init_done = 1'b0;
    bit         xfer_last;
    logic [31:0] cap;
    int          ncap;

    fsm_bit_serializer #(.WIDTH(WIDTH), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .shift_en(shift_en), .w(w), .w_valid(w_valid), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: queue of frame bits still to appear; front is the bit on w now.
    task automatic step(input logic r, input logic dv, input logic [WIDTH-1:0] d, input logic se);
        bit exp_ready;
        @(negedge clock);
        reset = r; data_valid = dv; data_in = d; shift_en = se;
        #1;
        exp_ready = (q.size() == 0) || (q.size() == 1 && se);
        if (init_done) begin
            check("w",          {31'b0, w},          {31'b0, (q.size() > 0) ? q[0] : 1'b0});
            check("w_valid",    {31'b0, w_valid},    {31'b0, q.size() > 0});
            check("busy",       {31'b0, busy},       {31'b0, q.size() > 0});
            check("data_ready", {31'b0, data_ready}, {31'b0, exp_ready});
            check("no_x", {31'b0, $isunknown({w, w_valid, busy, data_ready})}, 32'd0);
            if (w_valid === 1'b1) begin
                cap = {cap[30:0], w};
                ncap++;
            end
        end
        xfer_last = r && dv && exp_ready;
        if (!r) begin
            q.delete();
            init_done = 1'b1;
        end else begin
            if (se && q.size() > 0) void'(q.pop_front());
            if (xfer_last) begin
                for (int i = WIDTH - 1; i >= 0; i--) q.push_back(d[i]);
`ifdef SERIALIZER_PARITY_EN
                q.push_back(^d);
`endif
            end
        end
    endtask

    task automatic idle_out(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, 1'b1);
    endtask

    logic [31:0] exp_single, exp_b2b;

    initial begin
`ifdef SERIALIZER_PARITY_EN
        exp_single = 32'b11011;
        exp_b2b    = 32'b1101110111;
`else
        exp_single = 32'b1101;
        exp_b2b    = 32'b11011011;
`endif
        // single word after 2-cycle reset
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b1, 4'b1101, 1'b1);
        cap = 0; ncap = 0;
        step(1'b1, 1'b1, 4'b1101, 1'b1);
        check("single_xfer", {31'b0, xfer_last}, 32'd1);
        idle_out(FR + 2);
        check("single_bits", cap, exp_single);
        check("single_len", ncap, FR);

        // back-to-back: second word held until accepted on last bit
        cap = 0; ncap = 0;
        step(1'b1, 1'b1, 4'b1101, 1'b1);
        for (int i = 0; i < 3 * FR; i++) begin
            step(1'b1, 1'b1, 4'b1011, 1'b1);
            if (xfer_last) break;
        end
        check("b2b_second_taken", {31'b0, xfer_last}, 32'd1);
        idle_out(FR + 2);
        check("b2b_bits", cap, exp_b2b);
        check("b2b_len", ncap, 2 * FR);

        // stall after the 2nd bit
        cap = 0; ncap = 0;
        step(1'b1, 1'b1, 4'b1101, 1'b1);
        step(1'b1, 1'b0, '0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
        idle_out(FR + 2);
        check("stall_len", ncap, FR + 2);

        // reset during the 3rd bit
        step(1'b1, 1'b1, 4'b1011, 1'b1);
        step(1'b1, 1'b0, '0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b1);
        step(1'b0, 1'b1, 4'b0110, 1'b1);
        check("rst_wins", {31'b0, q.size() == 0}, 32'd1);
        idle_out(3);

        // blocked handshake from bit 2
        step(1'b1, 1'b1, 4'b1001, 1'b1);
        step(1'b1, 1'b0, '0, 1'b1);
        for (int i = 0; i < 3 * FR; i++) begin
            step(1'b1, 1'b1, 4'b0110, 1'b1);
            if (xfer_last) break;
        end
        check("blocked_taken", {31'b0, xfer_last}, 32'd1);
        idle_out(FR + 2);

        // randomized traffic with a source that holds until transfer
        begin
            logic             dv = 1'b0;
            logic [WIDTH-1:0] d = '0;
            for (int n = 0; n < 4000; n++) begin
                logic r, se;
                if (!dv || xfer_last) begin
                    dv = ($urandom_range(0, 3) != 0);
                    d  = WIDTH'($urandom);
                end
                r  = ($urandom_range(0, 79) != 0);
                se = ($urandom_range(0, 4) != 0);
                step(r, dv, d, se);
                if (!r) xfer_last = 1'b1;
            end
        end
        idle_out(FR + 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
